// File: rtl/i232c_defs.sv
// i232c_defs: parity modes, receiver state encoding and parity check shared by the UART receiver
package i232c_defs;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} rx_state_t;
  function automatic logic parity_bad(input logic [7:0] d, input logic p, input int mode);
    return (^d ^ p) != (mode == PAR_ODD);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO, push+pop allowed together even when full, drops and flags pushes when full
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic rd_ok, wr_ok;
  // a pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop
  always_comb begin
    rd_ok = rd && count != '0;
    wr_ok = wr && (count != (AW+1)'(DEPTH) || rd_ok);
    valid = count != '0;
    rdata = valid ? mem[rp] : '0;
  end
  // storage array, written only on accepted pushes
  always_ff @(posedge clk)
    if (wr_ok) mem[wp] <= wdata;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf   <= wr && !wr_ok;
      wp    <= wp + AW'(wr_ok);
      rp    <= rp + AW'(rd_ok);
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end
endmodule

// File: rtl/i232c_rx_fifo.sv
// i232c_rx_fifo: oversampling UART receiver with parity/stop checking feeding a show-ahead FIFO
module i232c_rx_fifo import i232c_defs::*; #(
  parameter logic [15:0] WTIME      = 16'h0006,
  parameter int          DATA_BITS  = 8,
  parameter int          PARITY     = 0,
  parameter int          STOP_BITS  = 1,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          XRST,
  input  logic                          RX,
  output logic [7:0]                    DATA,
  output logic                          VALID,
  input  logic                          RD_EN,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  output logic                          FRAME_ERR,
  output logic                          PARITY_ERR,
  output logic                          OVERRUN
);
  localparam logic [15:0] HALF   = WTIME / 16'd2 - 16'd1;
  localparam logic [15:0] RELOAD = WTIME - 16'd1;
  localparam logic [2:0]  LAST   = 3'(DATA_BITS - 1);
  rx_state_t   state;
  logic [1:0]  sync, live;
  logic        rx_s, armed, push, par_bad, stop_idx;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  assign rx_s = sync[1];
  // two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge CLK) begin
    if (!XRST) sync <= 2'b11;
    else sync <= {sync[0], RX};
  end
  // receiver: timer counts down to each sample point; live marks when the synchroniser carries real RX samples
  always_ff @(posedge CLK) begin
    if (!XRST) begin
      state      <= ST_IDLE;
      live       <= 2'b00;
      armed      <= 1'b0;
      push       <= 1'b0;
      par_bad    <= 1'b0;
      stop_idx   <= 1'b0;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      FRAME_ERR  <= 1'b0;
      PARITY_ERR <= 1'b0;
    end else begin
      live       <= {live[0], 1'b1};
      push       <= 1'b0;
      FRAME_ERR  <= 1'b0;
      PARITY_ERR <= 1'b0;
      if (state != ST_IDLE && timer != '0) begin
        timer <= timer - 16'd1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!rx_s && armed) begin
              state <= ST_START;
              timer <= HALF;
            end else if (rx_s && live[1]) begin
              armed <= 1'b1;
            end
          end
          ST_START: begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              timer   <= RELOAD;
              bit_idx <= '0;
              shreg   <= '0;
            end
          end
          ST_DATA: begin
            shreg[bit_idx] <= rx_s;
            timer          <= RELOAD;
            if (bit_idx == LAST) begin
              state    <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
              stop_idx <= 1'b0;
              par_bad  <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
          ST_PAR: begin
            par_bad  <= parity_bad(shreg, rx_s, PARITY);
            state    <= ST_STOP;
            timer    <= RELOAD;
            stop_idx <= 1'b0;
          end
          ST_STOP: begin
            if (!rx_s) begin
              FRAME_ERR <= 1'b1;
              armed     <= 1'b0;
              state     <= ST_IDLE;
            end else if (stop_idx == 1'(STOP_BITS - 1)) begin
              state      <= ST_IDLE;
              PARITY_ERR <= par_bad;
              push       <= !par_bad;
            end else begin
              stop_idx <= 1'b1;
              timer    <= RELOAD;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (XRST),
    .wr    (push),
    .wdata (shreg),
    .rd    (RD_EN),
    .rdata (DATA),
    .valid (VALID),
    .count (COUNT),
    .ovf   (OVERRUN)
  );
endmodule
